// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined ripple-carry adder.
//   calc_nstage()       - number of pipeline stages (and latency) for a WIDTH/CHUNK pair
//   stage_ctrl_t        - per-stage control record: valid, slice carry-out, running overflow
//   ADDER_CHECK_CHUNK() - elaboration-time guard that CHUNK is non-zero and divides WIDTH
`ifndef ADDER_PKG_SV
`define ADDER_PKG_SV

`define ADDER_CHECK_CHUNK(w, c) \
    if (((c) == 0) || (((w) % (c)) != 0)) begin : g_bad_chunk \
        $error("pipelined_rca_adder: WIDTH must be a non-zero multiple of CHUNK"); \
    end

package adder_pkg;

    function automatic int unsigned calc_nstage(input int unsigned width,
                                                input int unsigned chunk);
        return width / chunk;
    endfunction

    // ovf is the signed overflow of everything resolved so far; only the last
    // stage's value is the full-width flag.
    typedef struct packed {
        logic valid;
        logic carry;
        logic ovf;
    } stage_ctrl_t;

endpackage

`endif

// File: rtl/rca_slice.sv
// Combinational CHUNK-bit ripple-carry adder slice.
//   a, b   in  CHUNK  slice operands
//   cin    in  1      carry into bit 0
//   sum    out CHUNK  slice sum
//   cout   out 1      carry out of the slice MSB
//   c_msb  out 1      carry into the slice MSB (for signed overflow)
module rca_slice #(
    parameter int unsigned CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic [CHUNK:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < int'(CHUNK); i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout  = c[CHUNK];
    assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/pipelined_rca_adder.sv
// Pipelined WIDTH-bit add/subtract unit built from CHUNK-bit ripple-carry slices,
// one register stage per slice, latency NSTAGE = WIDTH/CHUNK, throughput 1 op/cycle.
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   in_valid / in_ready  operand handshake
//   a, b, cin, sub       operands, carry/borrow-in, 0 = add / 1 = subtract
//   out_valid/out_ready  result handshake
//   sum, cout, ovf       result, raw MSB carry-out, signed overflow
module pipelined_rca_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NSTAGE = calc_nstage(WIDTH, CHUNK);

    `ADDER_CHECK_CHUNK(WIDTH, CHUNK)

    logic advance;

    // Values entering stage k. Operands are kept right-aligned so the slice a
    // stage consumes is always at the LSBs.
    logic [WIDTH-1:0] stg_a     [NSTAGE];
    logic [WIDTH-1:0] stg_b     [NSTAGE];
    logic [WIDTH-1:0] stg_sum   [NSTAGE];
    logic             stg_valid [NSTAGE];
    logic             stg_carry [NSTAGE];

    // Pipeline registers: skew_*_q[k] feeds stage k (index 0 unused, stage 0
    // takes the ports directly); sum_q/ctrl_q[k] hold stage k's output.
    logic [WIDTH-1:0] skew_a_q  [NSTAGE];
    logic [WIDTH-1:0] skew_b_q  [NSTAGE];
    logic [WIDTH-1:0] sum_q     [NSTAGE];
    stage_ctrl_t      ctrl_q    [NSTAGE];

    for (genvar k = 0; k < int'(NSTAGE); k++) begin : g_stage
        logic [CHUNK-1:0] s_sum;
        logic             s_cout;
        logic             s_cmsb;

        if (k == 0) begin : g_in
            // Subtract folds into the operands here; no mode bit travels the pipe.
            assign stg_a[k]     = a;
            assign stg_b[k]     = b ^ {WIDTH{sub}};
            assign stg_carry[k] = cin ^ sub;
            assign stg_valid[k] = in_valid;
            assign stg_sum[k]   = '0;
        end else begin : g_link
            assign stg_a[k]     = skew_a_q[k];
            assign stg_b[k]     = skew_b_q[k];
            assign stg_carry[k] = ctrl_q[k-1].carry;
            assign stg_valid[k] = ctrl_q[k-1].valid;
            assign stg_sum[k]   = sum_q[k-1];
        end

        rca_slice #(
            .CHUNK (CHUNK)
        ) u_slice (
            .a     (stg_a[k][CHUNK-1:0]),
            .b     (stg_b[k][CHUNK-1:0]),
            .cin   (stg_carry[k]),
            .sum   (s_sum),
            .cout  (s_cout),
            .c_msb (s_cmsb)
        );

        // New slice enters at the top and older slices shift down, so after
        // the last stage slice 0 sits at bit 0.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                ctrl_q[k] <= '0;
                sum_q[k]  <= '0;
            end else if (advance) begin
                ctrl_q[k].valid <= stg_valid[k];
                ctrl_q[k].carry <= s_cout;
                ctrl_q[k].ovf   <= s_cmsb ^ s_cout;
                sum_q[k]        <= (stg_sum[k] >> CHUNK) | (WIDTH'(s_sum) << (WIDTH - CHUNK));
            end
        end

        if (k < int'(NSTAGE) - 1) begin : g_skew
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    skew_a_q[k+1] <= '0;
                    skew_b_q[k+1] <= '0;
                end else if (advance) begin
                    skew_a_q[k+1] <= stg_a[k] >> CHUNK;
                    skew_b_q[k+1] <= stg_b[k] >> CHUNK;
                end
            end
        end
    end

    assign out_valid = ctrl_q[NSTAGE-1].valid;
    assign sum       = sum_q[NSTAGE-1];
    assign cout      = ctrl_q[NSTAGE-1].carry;
    assign ovf       = ctrl_q[NSTAGE-1].ovf;

    // Single global stall: the whole pipe freezes while a result waits.
    assign advance   = !(out_valid && !out_ready);
    assign in_ready  = advance;

endmodule

// File: tb/tb_pipelined_rca_adder.sv
// Self-checking bench: three instances (CHUNK = 4, 16, 1) share stimulus; a
// scoreboard per instance checks every result, its latency and output hold
// under backpressure, plus table-driven and hand-written corner sequences.
module tb_pipelined_rca_adder;

    localparam int unsigned W  = 16;
    localparam int          ND = 3;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_ready;

    logic         in_ready_w  [ND];
    logic         out_valid_w [ND];
    logic [W-1:0] sum_w       [ND];
    logic         cout_w      [ND];
    logic         ovf_w       [ND];

    int checks   = 0;
    int failures = 0;
    int edge_cnt = 0;

    pipelined_rca_adder #(.WIDTH(16), .CHUNK(4)) u_c4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[0]),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid_w[0]),
        .out_ready(out_ready), .sum(sum_w[0]), .cout(cout_w[0]), .ovf(ovf_w[0])
    );
    pipelined_rca_adder #(.WIDTH(16), .CHUNK(16)) u_c16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[1]),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid_w[1]),
        .out_ready(out_ready), .sum(sum_w[1]), .cout(cout_w[1]), .ovf(ovf_w[1])
    );
    pipelined_rca_adder #(.WIDTH(16), .CHUNK(1)) u_c1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[2]),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid_w[2]),
        .out_ready(out_ready), .sum(sum_w[2]), .cout(cout_w[2]), .ovf(ovf_w[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt++;

    function automatic int lat_of(input int d);
        return (d == 0) ? 4 : ((d == 1) ? 1 : 16);
    endfunction

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } res_t;

    // Reference: plain integer arithmetic on the operand values.
    function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic ci, input logic sb);
        res_t     r;
        int       sx;
        int       sy;
        int       sr;
        logic [W:0] full;
        sx = $signed(x);
        sy = $signed(y);
        if (!sb) begin
            full = {1'b0, x} + {1'b0, y} + 17'(ci);
            sr   = sx + sy + int'(ci);
        end else begin
            full = {1'b0, x} + {1'b0, ~y} + 17'(!ci);
            sr   = sx - sy - int'(ci);
        end
        r.s = full[W-1:0];
        r.c = full[W];
        r.o = (sr > 32767) || (sr < -32768);
        return r;
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct {
        res_t r;
        int   n;
        int   st;
    } exp_t;

    exp_t         fifo       [ND][64];
    int           wr         [ND];
    int           rd         [ND];
    int           stall_cnt  [ND];
    logic         prev_stall [ND];
    logic [W-1:0] prev_sum   [ND];
    logic         prev_c     [ND];
    logic         prev_o     [ND];

    initial begin
        for (int d = 0; d < ND; d++) begin
            wr[d] = 0; rd[d] = 0; stall_cnt[d] = 0; prev_stall[d] = 1'b0;
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < ND; d++) begin
            if (rst) begin
                wr[d] = 0;
                rd[d] = 0;
                prev_stall[d] = 1'b0;
            end else begin
                if (prev_stall[d]) begin
                    checks++;
                    if (out_valid_w[d] !== 1'b1 || sum_w[d] !== prev_sum[d] ||
                        cout_w[d] !== prev_c[d] || ovf_w[d] !== prev_o[d]) begin
                        failures++;
                        $display("FAIL hold dut%0d: got v=%b s=%h c=%b o=%b, want v=1 s=%h c=%b o=%b",
                                 d, out_valid_w[d], sum_w[d], cout_w[d], ovf_w[d],
                                 prev_sum[d], prev_c[d], prev_o[d]);
                    end
                end
                if (out_valid_w[d] === 1'b1 && out_ready) begin
                    checks++;
                    if (rd[d] == wr[d]) begin
                        failures++;
                        $display("FAIL stray_output dut%0d: got s=%h with nothing outstanding, want none",
                                 d, sum_w[d]);
                    end else begin
                        exp_t e;
                        int   lat;
                        e = fifo[d][rd[d] % 64];
                        rd[d]++;
                        if (sum_w[d] !== e.r.s || cout_w[d] !== e.r.c || ovf_w[d] !== e.r.o) begin
                            failures++;
                            $display("FAIL result dut%0d: got s=%h c=%b o=%b, want s=%h c=%b o=%b",
                                     d, sum_w[d], cout_w[d], ovf_w[d], e.r.s, e.r.c, e.r.o);
                        end
                        lat = edge_cnt - e.n - (stall_cnt[d] - e.st);
                        checks++;
                        if (lat != lat_of(d)) begin
                            failures++;
                            $display("FAIL latency dut%0d: got %0d, want %0d", d, lat, lat_of(d));
                        end
                    end
                end
                if (in_valid && in_ready_w[d] === 1'b1) begin
                    fifo[d][wr[d] % 64] = '{r: model(a, b, cin, sub), n: edge_cnt, st: stall_cnt[d]};
                    wr[d]++;
                end
                prev_stall[d] = (out_valid_w[d] === 1'b1) && !out_ready;
                if (prev_stall[d]) stall_cnt[d]++;
                prev_sum[d] = sum_w[d];
                prev_c[d]   = cout_w[d];
                prev_o[d]   = ovf_w[d];
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_reset_state(input string tag);
        for (int d = 0; d < ND; d++) begin
            checks++;
            if (out_valid_w[d] !== 1'b0 || sum_w[d] !== '0 || cout_w[d] !== 1'b0 ||
                ovf_w[d] !== 1'b0 || in_ready_w[d] !== 1'b1) begin
                failures++;
                $display("FAIL %s dut%0d: got v=%b s=%h c=%b o=%b rdy=%b, want v=0 s=0 c=0 o=0 rdy=1",
                         tag, d, out_valid_w[d], sum_w[d], cout_w[d], ovf_w[d], in_ready_w[d]);
            end
        end
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } vec_t;

    // One op into an idle pipe; checks the CHUNK=4 instance against the table
    // entry and that it emerges exactly 4 cycles after the accepting edge.
    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        out_ready = 1'b1;
        a = v.a; b = v.b; cin = v.cin; sub = v.sub;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (out_valid_w[0] !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        checks++;
        if (out_valid_w[0] !== 1'b1 || sum_w[0] !== v.s || cout_w[0] !== v.c || ovf_w[0] !== v.o) begin
            failures++;
            $display("FAIL %s: got v=%b s=%h c=%b o=%b, want v=1 s=%h c=%b o=%b",
                     tag, out_valid_w[0], sum_w[0], cout_w[0], ovf_w[0], v.s, v.c, v.o);
        end
        checks++;
        if (lat != 4) begin
            failures++;
            $display("FAIL %s_latency: got %0d, want 4", tag, lat);
        end
    endtask

    function automatic logic [W-1:0] pick_operand();
        logic [W-1:0] corner [4];
        corner[0] = 16'hFFFF; corner[1] = 16'h8000; corner[2] = 16'h7FFF; corner[3] = 16'h0000;
        if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 3)];
        return W'($urandom);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running, want finished");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        vec_t vecs [8];
        logic [15:0] vmask;
        logic [15:0] vexp;
        logic [W-1:0] held;

        vecs[0] = '{16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[5] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        vecs[7] = '{16'h0010, 16'h0005, 1'b1, 1'b1, 16'h000A, 1'b1, 1'b0};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check_reset_state("reset_state");

        for (int i = 0; i < 8; i++) begin
            idle(20);
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Back-to-back stream of 8 ops.
        idle(20);
        vmask = '0;
        for (int i = 0; i < 16; i++) begin
            if (i < 8) begin
                in_valid = 1'b1;
                a = pick_operand(); b = pick_operand();
                cin = 1'($urandom); sub = 1'($urandom);
            end else begin
                in_valid = 1'b0;
            end
            tick();
            vmask[i] = out_valid_w[0];
        end
        vexp = 16'h07F8;
        checks++;
        if (vmask !== vexp) begin
            failures++;
            $display("FAIL stream_valid_pattern: got %b, want %b", vmask, vexp);
        end

        // Backpressure: 3 stalled cycles with a result waiting.
        idle(20);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            a = pick_operand(); b = pick_operand();
            cin = 1'($urandom); sub = 1'($urandom);
            tick();
        end
        out_ready = 1'b0;
        held = sum_w[0];
        a = pick_operand();
        for (int j = 0; j < 3; j++) begin
            tick();
            checks++;
            if (in_ready_w[0] !== 1'b0 || out_valid_w[0] !== 1'b1 || sum_w[0] !== held) begin
                failures++;
                $display("FAIL backpressure%0d: got rdy=%b v=%b s=%h, want rdy=0 v=1 s=%h",
                         j, in_ready_w[0], out_valid_w[0], sum_w[0], held);
            end
        end
        idle(24);

        // Reset with 3 ops in flight.
        idle(20);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a = pick_operand(); b = pick_operand();
            cin = 1'($urandom); sub = 1'($urandom);
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        for (int d = 0; d < ND; d++) begin
            checks++;
            if (out_valid_w[d] !== 1'b0) begin
                failures++;
                $display("FAIL async_reset dut%0d: got out_valid=%b, want 0", d, out_valid_w[d]);
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_state("post_reset_state");
        idle(20);
        run_vec(vecs[0], "after_reset");
        idle(20);

        // Randomised traffic with random backpressure.
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            a = pick_operand(); b = pick_operand();
            cin = 1'($urandom); sub = 1'($urandom);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (rd[0] == wr[0] && rd[1] == wr[1] && rd[2] == wr[2]) break;
            tick();
        end
        for (int d = 0; d < ND; d++) begin
            checks++;
            if (rd[d] != wr[d]) begin
                failures++;
                $display("FAIL drain dut%0d: got %0d outstanding, want 0", d, wr[d] - rd[d]);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
